usib_cmd_master: RTL and testbench
==================================

// Module: usib_cmd_master
// PURPOSE
//  Bus-master sequencer directly upstream of the USIB interconnect. Accepts one CSR command at a time
//  (valid/ready), drives the master address/write-data ports with the [31:30] command encoding, and for reads
//  holds the block ID while waiting a fixed round-trip latency, then captures read data and returns a response.
//  Commands come from a host-side source (UART/MIDI parser); CSRs live in the slave blocks behind USIB.
// PARAMETERS
//  pUsiBusWidth     32  master address/data bus width
//  pCsrAdrsWidth    16  CSR address field width, bits [pCsrAdrsWidth-1:0]
//  pBlockAdrsWidth   3  block ID width, placed directly above the CSR field
//  pRdLatency        3  cycles from first read-address cycle to the cycle oMUsiRd is sampled (min 2, max 15)
// PORTS
//  iSCLK       in   1                              bus clock; the only clock
//  iSRSTn      in   1                              synchronous reset, active-low
//  iCmdVd      in   1                              command valid
//  oCmdRdy     out  1                              command ready, high only in IDLE
//  iCmdWr      in   1                              1 = write, 0 = read
//  iCmdAdrs    in   pBlockAdrsWidth+pCsrAdrsWidth  {block ID, CSR address}
//  iCmdWd      in   pUsiBusWidth                   write data
//  oRspVd      out  1                              response valid, held until accepted
//  iRspRdy     in   1                              response ready
//  oRspRd      out  pUsiBusWidth                   read data (0 for write acknowledge)
//  oMUsiAdrs   out  pUsiBusWidth                   to USIB master address port
//  oMUsiWd     out  pUsiBusWidth                   to USIB master write-data port
//  iMUsiRd     in   pUsiBusWidth                   from USIB master read-data port
// BEHAVIOUR
//  Reset (iSRSTn=0 at a rising edge): all outputs 0 except oCmdRdy, which is 0 while reset is applied and goes
//   to 1 in the first cycle after reset is released; state IDLE; latency counter 0.
//   Reset mid-transaction aborts the transaction and drops any pending response.
//  oMUsiAdrs layout: [31:30] cmd (00 idle, 01 write, 10 read; 11 never issued), [29:(pCsrAdrsWidth+pBlockAdrsWidth)] 0,
//   block ID, CSR address. All outputs are registered.
//  States:
//   IDLE    oCmdRdy=1; oMUsiAdrs=0, oMUsiWd=0. On iCmdVd&oCmdRdy latch the command; write -> WDRV, read -> RDRV.
//   WDRV    1 cycle: oMUsiAdrs={01,..,adrs}, oMUsiWd=wd. Next: IDLE, or RESP when USIB_MST_WR_ACK_EN is defined.
//   RDRV    1 cycle: oMUsiAdrs={10,..,adrs}; counter loaded with pRdLatency-1 -> RWAIT.
//   RWAIT   oMUsiAdrs={00,..,adrs}: block ID and CSR address held so the USIB read mux stays selected.
//           Counter decrements each cycle; at 0, capture iMUsiRd into oRspRd -> RESP.
//   RESP    oRspVd=1, oMUsiAdrs=0; on iRspRdy -> IDLE (oRspVd=0 from the next cycle). oRspRd is stable while oRspVd=1.
//  Latency: read = 1 accept cycle + pRdLatency + 1, then the response is presented.
//   Write throughput: 1 command per 2 cycles (no ack).
//  iCmdVd is ignored outside IDLE. iRspRdy is ignored outside RESP.
//   Command inputs are sampled only on the accept edge.
//  Command field values are latched exactly as given; block ID values above the connected block count are the
//   interconnect's concern.
// CONFIGURATION
//  USIB_MST_WR_ACK_EN defined: every write passes through RESP with oRspRd=0 and needs iRspRdy.
//   Undefined: writes return WDRV->IDLE with no response; only reads ever assert oRspVd.
// STRUCTURE
//  Shared package usib_pkg: command encodings (USIB_CMD_IDLE/WR/RD/WR_RD = 2'b00/01/10/11),
//   field positions (USIB_CMD_MSB=31, USIB_CMD_LSB=30), and the state enum.
//  No sub-module; the FSM, latency counter and output registers are all inline.
// TESTING
//  1 Reset then a write to adrs {3'd1,16'h0010}, wd=32'hA5A5_0001 -> exactly one cycle with
//    oMUsiAdrs=32'h4001_0010 and oMUsiWd=A5A5_0001, then oMUsiAdrs=0; oRspVd stays 0 (no WR_ACK).
//  2 Read {3'd2,16'h0004}, model returns 32'hDEAD_BEEF at the pRdLatency sample -> RDRV drives 32'h8002_0004;
//    RWAIT holds 32'h0002_0004; oRspVd=1 with oRspRd=DEAD_BEEF; oCmdRdy=0 throughout.
//  3 Hold iRspRdy=0 for 5 cycles in RESP -> oRspVd and oRspRd stay stable;
//    a new iCmdVd is not accepted until 1 cycle after iRspRdy.
//  4 Back-to-back writes with iCmdVd held high -> accepted every 2nd cycle; oMUsiAdrs alternates cmd 01 / 00.
//  5 Assert iSRSTn=0 during RWAIT -> next cycle all outputs 0; no response; a fresh read afterwards completes
//    correctly.
//  6 USIB_MST_WR_ACK_EN defined: write -> oRspVd=1 with oRspRd=0; the FSM returns to IDLE only after iRspRdy.

Source files
------------

// File: rtl/usib_pkg.sv
// Shared definitions for the USIB command master.
//   - Command encodings carried in the top two bits of the master address bus.
//   - Bit positions of the command field.
//   - State encoding of the command sequencer.
package usib_pkg;

  localparam logic [1:0] USIB_CMD_IDLE  = 2'b00;
  localparam logic [1:0] USIB_CMD_WR    = 2'b01;
  localparam logic [1:0] USIB_CMD_RD    = 2'b10;
  localparam logic [1:0] USIB_CMD_WR_RD = 2'b11;  // reserved; never issued by the master

  localparam int USIB_CMD_MSB = 31;
  localparam int USIB_CMD_LSB = 30;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDRV  = 3'd1,
    ST_RDRV  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4
  } usib_mst_state_e;

endpackage

// File: rtl/usib_cmd_master.sv
// usib_cmd_master
//   Bus-master sequencer feeding the USIB interconnect. Takes one CSR command at
//   a time over a valid/ready handshake, drives the master address / write-data
//   ports with the command encoding in [31:30], and for reads keeps the block ID
//   and CSR address on the bus for a fixed round-trip latency before capturing
//   the read data and presenting it as a response.
//
//   Optional feature macro: USIB_MST_WR_ACK_EN
//     defined   : every write also produces a response (oRspRd = 0) and waits
//                 for iRspRdy before the next command is accepted.
//     undefined : writes return straight to IDLE; only reads respond.
//
// Ports
//   iSCLK      bus clock
//   iSRSTn     synchronous reset, active low
//   iCmdVd     command valid
//   oCmdRdy    command ready (high only in IDLE)
//   iCmdWr     1 = write, 0 = read
//   iCmdAdrs   {block ID, CSR address}
//   iCmdWd     write data
//   oRspVd     response valid, held until iRspRdy
//   iRspRdy    response ready
//   oRspRd     read data (0 for a write acknowledge)
//   oMUsiAdrs  USIB master address port {cmd, zero pad, block ID, CSR address}
//   oMUsiWd    USIB master write-data port
//   iMUsiRd    USIB master read-data port
// All outputs come straight from flops.
module usib_cmd_master
  import usib_pkg::*;
#(
  parameter int pUsiBusWidth    = 32,
  parameter int pCsrAdrsWidth   = 16,
  parameter int pBlockAdrsWidth = 3,
  parameter int pRdLatency      = 3
) (
  input  logic                                     iSCLK,
  input  logic                                     iSRSTn,
  input  logic                                     iCmdVd,
  output logic                                     oCmdRdy,
  input  logic                                     iCmdWr,
  input  logic [pBlockAdrsWidth+pCsrAdrsWidth-1:0] iCmdAdrs,
  input  logic [pUsiBusWidth-1:0]                  iCmdWd,
  output logic                                     oRspVd,
  input  logic                                     iRspRdy,
  output logic [pUsiBusWidth-1:0]                  oRspRd,
  output logic [pUsiBusWidth-1:0]                  oMUsiAdrs,
  output logic [pUsiBusWidth-1:0]                  oMUsiWd,
  input  logic [pUsiBusWidth-1:0]                  iMUsiRd
);

  localparam int ADRS_W = pBlockAdrsWidth + pCsrAdrsWidth;

  usib_mst_state_e          state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADRS_W-1:0]        adrs_q, adrs_d;
  logic [pUsiBusWidth-1:0]  wd_q, wd_d;
  logic [pUsiBusWidth-1:0]  m_adrs_q, m_adrs_d;
  logic [pUsiBusWidth-1:0]  m_wd_q, m_wd_d;
  logic [pUsiBusWidth-1:0]  rsp_rd_q, rsp_rd_d;
  logic                     rsp_vd_q, rsp_vd_d;
  logic                     cmd_rdy_q, cmd_rdy_d;

  // Compose a master address word: command in the top field, zero padding,
  // then block ID and CSR address in the low bits.
  function automatic logic [pUsiBusWidth-1:0] bus_adrs(input logic [1:0] cmd,
                                                       input logic [ADRS_W-1:0] a);
    logic [pUsiBusWidth-1:0] r;
    r = '0;
    r[ADRS_W-1:0] = a;
    r[USIB_CMD_MSB:USIB_CMD_LSB] = cmd;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adrs_d   = adrs_q;
    wd_d     = wd_q;
    rsp_rd_d = rsp_rd_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_rdy_q gates acceptance so nothing is taken in the cycle right
        // after reset release, when ready is still low.
        if (iCmdVd && cmd_rdy_q) begin
          adrs_d  = iCmdAdrs;
          wd_d    = iCmdWd;
          state_d = iCmdWr ? ST_WDRV : ST_RDRV;
        end
      end
      ST_WDRV: begin
`ifdef USIB_MST_WR_ACK_EN
        rsp_rd_d = '0;
        state_d  = ST_RESP;
`else
        state_d  = ST_IDLE;
`endif
      end
      ST_RDRV: begin
        cnt_d   = 4'(pRdLatency - 1);
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_rd_d = iMUsiRd;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (iRspRdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    m_adrs_d  = '0;
    m_wd_d    = '0;
    rsp_vd_d  = 1'b0;
    cmd_rdy_d = 1'b0;
    unique case (state_d)
      ST_IDLE:  cmd_rdy_d = 1'b1;
      ST_WDRV: begin
        m_adrs_d = bus_adrs(USIB_CMD_WR, adrs_d);
        m_wd_d   = wd_d;
      end
      ST_RDRV:  m_adrs_d = bus_adrs(USIB_CMD_RD, adrs_d);
      // Address kept with an idle command so the interconnect read mux stays
      // pointed at the target block during the round trip.
      ST_RWAIT: m_adrs_d = bus_adrs(USIB_CMD_IDLE, adrs_d);
      ST_RESP:  rsp_vd_d = 1'b1;
      default:  cmd_rdy_d = 1'b0;
    endcase
  end

  always_ff @(posedge iSCLK) begin
    if (!iSRSTn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      adrs_q    <= '0;
      wd_q      <= '0;
      m_adrs_q  <= '0;
      m_wd_q    <= '0;
      rsp_rd_q  <= '0;
      rsp_vd_q  <= 1'b0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adrs_q    <= adrs_d;
      wd_q      <= wd_d;
      m_adrs_q  <= m_adrs_d;
      m_wd_q    <= m_wd_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_vd_q  <= rsp_vd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign oCmdRdy   = cmd_rdy_q;
  assign oRspVd    = rsp_vd_q;
  assign oRspRd    = rsp_rd_q;
  assign oMUsiAdrs = m_adrs_q;
  assign oMUsiWd   = m_wd_q;

endmodule

// File: tb/tb_usib_cmd_master.sv
// Scoreboard bench for usib_cmd_master. Stimulus pushes expected bus cycles
// and responses into queues; two monitors pop and compare them as the DUT
// presents bus commands and response handshakes.
module tb_usib_cmd_master;

  logic        clk = 1'b0;
  logic        iSRSTn;
  logic        iCmdVd;
  logic        oCmdRdy;
  logic        iCmdWr;
  logic [18:0] iCmdAdrs;
  logic [31:0] iCmdWd;
  logic        oRspVd;
  logic        iRspRdy;
  logic [31:0] oRspRd;
  logic [31:0] oMUsiAdrs;
  logic [31:0] oMUsiWd;
  logic [31:0] iMUsiRd;

  always #5 clk = ~clk;

  usib_cmd_master dut (
    .iSCLK    (clk),
    .iSRSTn   (iSRSTn),
    .iCmdVd   (iCmdVd),
    .oCmdRdy  (oCmdRdy),
    .iCmdWr   (iCmdWr),
    .iCmdAdrs (iCmdAdrs),
    .iCmdWd   (iCmdWd),
    .oRspVd   (oRspVd),
    .iRspRdy  (iRspRdy),
    .oRspRd   (oRspRd),
    .oMUsiAdrs(oMUsiAdrs),
    .oMUsiWd  (oMUsiWd),
    .iMUsiRd  (iMUsiRd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] bus_adrs_q[$];
  logic [31:0] bus_wd_q[$];
  logic [31:0] rsp_q[$];

  // Slave model: returns model_val only while the addressed block is held with
  // an idle command (the wait phase of a read); anything else reads as junk.
  logic [18:0] model_adrs;
  logic [31:0] model_val;
  assign iMUsiRd = (oMUsiAdrs[31:30] == 2'b00 && oMUsiAdrs[18:0] == model_adrs && oMUsiAdrs != 32'h0)
                   ? model_val : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: every non-idle command cycle must match the next expectation.
  always @(negedge clk) begin
    if (oMUsiAdrs[31:30] != 2'b00) begin
      if (bus_adrs_q.size() == 0) begin
        check("bus_unexpected", oMUsiAdrs, 32'h0);
      end else begin
        logic [31:0] ea, ew;
        ea = bus_adrs_q.pop_front();
        ew = bus_wd_q.pop_front();
        $display("[TB] bus  adrs=%h wd=%h (exp %h/%h)", oMUsiAdrs, oMUsiWd, ea, ew);
        check("bus_adrs", oMUsiAdrs, ea);
        check("bus_wd", oMUsiWd, ew);
      end
    end
  end

  // Response monitor: compare on handshake, and check stability while stalled.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rd   = 32'h0;
  always @(negedge clk) begin
    if (oRspVd) begin
      if (prev_hold) check("rsp_stable", oRspRd, prev_rd);
      if (iRspRdy) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {31'b0, oRspVd}, 32'h0);
        end else begin
          logic [31:0] er;
          er = rsp_q.pop_front();
          $display("[TB] rsp  rd=%h (exp %h)", oRspRd, er);
          check("rsp_data", oRspRd, er);
        end
      end
    end
    prev_hold = oRspVd && !iRspRdy;
    prev_rd   = oRspRd;
  end

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!oCmdRdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!oCmdRdy) check("rdy_timeout", {31'b0, oCmdRdy}, 32'h1);
  endtask

  function automatic void push_cmd(input logic wr, input logic [18:0] a, input logic [31:0] wd,
                                   input logic exp_rsp, input logic [31:0] rsp);
    bus_adrs_q.push_back({(wr ? 2'b01 : 2'b10), 11'b0, a});
    bus_wd_q.push_back(wr ? wd : 32'h0);
    if (!wr && exp_rsp) rsp_q.push_back(rsp);
`ifdef USIB_MST_WR_ACK_EN
    if (wr) rsp_q.push_back(32'h0);
`endif
  endfunction

  // Waits for ready, presents one command for exactly the accept edge, and
  // returns just after that edge.
  task automatic issue(input logic wr, input logic [18:0] a, input logic [31:0] wd,
                       input logic exp_rsp, input logic [31:0] rsp);
    wait_rdy();
    push_cmd(wr, a, wd, exp_rsp, rsp);
    iCmdVd = 1'b1; iCmdWr = wr; iCmdAdrs = a; iCmdWd = wd;
    @(posedge clk);
    #1;
    iCmdVd = 1'b0; iCmdWr = 1'b0; iCmdAdrs = '0; iCmdWd = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] b2b_a[3];
    logic [31:0] b2b_w[3];
    int n;

    iSRSTn = 1'b0; iCmdVd = 1'b0; iCmdWr = 1'b0; iCmdAdrs = '0; iCmdWd = '0;
    iRspRdy = 1'b1; model_adrs = '0; model_val = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_rdy", {31'b0, oCmdRdy}, 32'h0);
    check("rst_rsp_vd", {31'b0, oRspVd}, 32'h0);
    check("rst_rsp_rd", oRspRd, 32'h0);
    check("rst_m_adrs", oMUsiAdrs, 32'h0);
    check("rst_m_wd", oMUsiWd, 32'h0);
    iSRSTn = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", {31'b0, oCmdRdy}, 32'h1);

    // 1: single write, expected bus word 4001_0010
    issue(1'b1, {3'd1, 16'h0010}, 32'hA5A5_0001, 1'b0, 32'h0);
    @(negedge clk);
`ifndef USIB_MST_WR_ACK_EN
    check("wr_no_rsp0", {31'b0, oRspVd}, 32'h0);
`endif
    @(negedge clk);
    check("wr_adrs_clear", oMUsiAdrs, 32'h0);
    check("wr_wd_clear", oMUsiWd, 32'h0);
`ifndef USIB_MST_WR_ACK_EN
    check("wr_no_rsp1", {31'b0, oRspVd}, 32'h0);
`endif

    // 2: read with latency profile, bus 8002_0004 then 0002_0004 held
    model_adrs = {3'd2, 16'h0004};
    model_val  = 32'hDEAD_BEEF;
    issue(1'b0, {3'd2, 16'h0004}, 32'h0, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rd_rdy_rdrv", {31'b0, oCmdRdy}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rd_hold_adrs", oMUsiAdrs, 32'h0002_0004);
      check("rd_rdy_wait", {31'b0, oCmdRdy}, 32'h0);
      check("rd_vd_wait", {31'b0, oRspVd}, 32'h0);
    end
    @(negedge clk);
    check("rd_vd_lat", {31'b0, oRspVd}, 32'h1);
    check("rd_rdy_resp", {31'b0, oCmdRdy}, 32'h0);
    @(negedge clk);
    check("rd_vd_drop", {31'b0, oRspVd}, 32'h0);
    check("rd_rdy_back", {31'b0, oCmdRdy}, 32'h1);

    // 3: stalled response; a pending write must wait for the handshake
    model_adrs = {3'd5, 16'h1234};
    model_val  = 32'h1234_5678;
    wait_rdy();
    @(posedge clk);
    #1;
    iRspRdy = 1'b0;
    issue(1'b0, {3'd5, 16'h1234}, 32'h0, 1'b1, 32'h1234_5678);
    push_cmd(1'b1, {3'd3, 16'h00FF}, 32'h0000_CAFE, 1'b0, 32'h0);
    iCmdVd = 1'b1; iCmdWr = 1'b1; iCmdAdrs = {3'd3, 16'h00FF}; iCmdWd = 32'h0000_CAFE;
    n = 0;
    @(negedge clk);
    while (!oRspVd && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_vd", {31'b0, oRspVd}, 32'h1);
      check("stall_rd", oRspRd, 32'h1234_5678);
      check("stall_no_cmd", oMUsiAdrs, 32'h0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    iRspRdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_idle_rdy", {31'b0, oCmdRdy}, 32'h1);
    check("stall_not_yet", oMUsiAdrs, 32'h0);
    @(negedge clk);
    check("stall_accepted", {31'b0, oCmdRdy}, 32'h0);
    iCmdVd = 1'b0; iCmdWr = 1'b0; iCmdAdrs = '0; iCmdWd = '0;

`ifndef USIB_MST_WR_ACK_EN
    // 4: back-to-back writes with valid held high
    b2b_a[0] = {3'd0, 16'h0000}; b2b_w[0] = 32'h0000_0001;
    b2b_a[1] = {3'd7, 16'hFFFF}; b2b_w[1] = 32'hFFFF_FFFF;
    b2b_a[2] = {3'd4, 16'h8001}; b2b_w[2] = 32'h0000_0000;
    wait_rdy();
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b1, b2b_a[i], b2b_w[i], 1'b0, 32'h0);
      iCmdVd = 1'b1; iCmdWr = 1'b1; iCmdAdrs = b2b_a[i]; iCmdWd = b2b_w[i];
      @(negedge clk);
      check("b2b_cmd_wr", {30'b0, oMUsiAdrs[31:30]}, 32'h1);
      @(negedge clk);
      check("b2b_cmd_idle", {30'b0, oMUsiAdrs[31:30]}, 32'h0);
      check("b2b_rdy", {31'b0, oCmdRdy}, 32'h1);
    end
    iCmdVd = 1'b0; iCmdWr = 1'b0; iCmdAdrs = '0; iCmdWd = '0;
`else
    // 6: acknowledged write waits for iRspRdy
    wait_rdy();
    @(posedge clk);
    #1;
    iRspRdy = 1'b0;
    issue(1'b1, {3'd1, 16'h0020}, 32'h0000_1234, 1'b0, 32'h0);
    @(negedge clk);
    check("ack_vd_wdrv", {31'b0, oRspVd}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ack_vd", {31'b0, oRspVd}, 32'h1);
      check("ack_rd_zero", oRspRd, 32'h0);
      check("ack_rdy_low", {31'b0, oCmdRdy}, 32'h0);
    end
    @(posedge clk);
    #1;
    iRspRdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ack_rdy_back", {31'b0, oCmdRdy}, 32'h1);
`endif

    // 5: reset during the read wait aborts; a fresh read then completes
    model_adrs = {3'd6, 16'h0100};
    model_val  = 32'h0BAD_F00D;
    issue(1'b0, {3'd6, 16'h0100}, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wait", oMUsiAdrs, 32'h0006_0100);
    iSRSTn = 1'b0;
    @(negedge clk);
    check("abort_m_adrs", oMUsiAdrs, 32'h0);
    check("abort_m_wd", oMUsiWd, 32'h0);
    check("abort_rsp_vd", {31'b0, oRspVd}, 32'h0);
    check("abort_rsp_rd", oRspRd, 32'h0);
    check("abort_rdy", {31'b0, oCmdRdy}, 32'h0);
    iSRSTn = 1'b1;
    issue(1'b0, {3'd6, 16'h0100}, 32'h0, 1'b1, 32'h0BAD_F00D);

    // Drain and make sure everything expected actually happened
    n = 0;
    while ((bus_adrs_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("bus_q_empty", 32'(bus_adrs_q.size()), 32'h0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
